// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: default dimensions and the
// bundler state encoding used across the HDC pipeline.
package hdc_pkg;

    localparam int HV_DIM        = 5000;
    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_THRESH,
        ST_OUT
    } bundler_state_t;

endpackage

// File: rtl/hv_bundler_if.sv
// Handshake bundle between the level-HV fetch stage, the bundler and the
// associative-search stage; the bundler sits on the slave side.
interface hv_bundler_if #(parameter int HV_DIM = hdc_pkg::HV_DIM);

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] level_hv;
    logic              out_valid;
    logic              out_ready;
    logic [HV_DIM-1:0] query_hv;
    logic              busy;

    modport master (
        output start, in_valid, level_hv, out_ready,
        input  in_ready, out_valid, query_hv, busy
    );

    modport slave (
        input  start, in_valid, level_hv, out_ready,
        output in_ready, out_valid, query_hv, busy
    );

endinterface

// File: rtl/hv_rotate.sv
// Combinational circular left rotation of a hypervector: dout[(i+sh)%HV_DIM] = din[i].
module hv_rotate #(
    parameter int HV_DIM = hdc_pkg::HV_DIM,
    parameter int SH_W   = 4
) (
    input  logic [HV_DIM-1:0] din,
    input  logic [SH_W-1:0]   sh,
    output logic [HV_DIM-1:0] dout
);

    logic [31:0] amt;

    // A zero amount shifts the right-hand term out entirely, so no special case is needed.
    always_comb begin
        amt  = 32'(sh) % 32'(HV_DIM);
        dout = (din << amt) | (din >> (32'(HV_DIM) - amt));
    end

endmodule

// File: rtl/hv_bundler.sv
// Position-binds WIN_LEN level hypervectors by rotation, bundles them in saturating
// per-dimension counters and thresholds the result into a query hypervector.
module hv_bundler
    import hdc_pkg::*;
#(
    parameter int HV_DIM  = hdc_pkg::HV_DIM,
    parameter int WIN_LEN = 10,
    parameter int CNT_W   = hdc_pkg::DEFAULT_CNT_W,
    parameter int THRESH  = 3
) (
    input  logic       clk,
    input  logic       rst,
    hv_bundler_if.slave bus
);

    localparam int                 IDX_W    = $clog2(WIN_LEN);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   THRESH_C = CNT_W'(THRESH);

    if (THRESH < 1 || THRESH > (2**CNT_W) - 1) begin : g_bad_thresh
        $error("hv_bundler: THRESH must lie in 1..2**CNT_W-1");
    end
    if (WIN_LEN < 2) begin : g_bad_win
        $error("hv_bundler: WIN_LEN must be at least 2");
    end

    bundler_state_t    state, next_state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt [HV_DIM];
    logic [HV_DIM-1:0] bound;
    logic [HV_DIM-1:0] query;
    logic              in_ready_s, out_valid_s, busy_s;
    logic              accept;

    hv_rotate #(.HV_DIM(HV_DIM), .SH_W(IDX_W)) u_rotate (
        .din  (bus.level_hv),
        .sh   (idx),
        .dout (bound)
    );

    assign accept = bus.in_valid && in_ready_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (bus.start)                   next_state = ST_ACCUM;
            ST_ACCUM:  if (accept && idx == IDX_LAST)   next_state = ST_THRESH;
            ST_THRESH:                                  next_state = ST_OUT;
            ST_OUT:    if (bus.out_ready)               next_state = ST_IDLE;
            default:                                    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state)
            ST_IDLE:  busy_s      = 1'b0;
            ST_ACCUM: in_ready_s  = 1'b1;
            ST_OUT:   out_valid_s = 1'b1;
            default:  ;
        endcase
    end

    // A new window starts from clean counters, so any aborted partial bundle is forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            for (int i = 0; i < HV_DIM; i++) cnt[i] <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            idx <= '0;
            for (int i = 0; i < HV_DIM; i++) cnt[i] <= '0;
        end else if (accept) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            for (int i = 0; i < HV_DIM; i++) begin
                if (bound[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // The query register is only refreshed in THRESH and otherwise holds for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            query <= '0;
        end else if (state == ST_THRESH) begin
            for (int i = 0; i < HV_DIM; i++) query[i] <= (cnt[i] >= THRESH_C);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.busy      = busy_s;
    assign bus.query_hv  = query;

endmodule
